// File: rtl/jpeg_huffman_decoder.sv
// jpeg_huffman_decoder: table-driven JPEG Huffman symbol decoder with a registered copy of the result
module jpeg_huffman_decoder #(
  parameter int H = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [H-1:0][27:0] huff_table,
  input  logic [15:0]       code,
  output logic [3:0]        run,
  output logic [3:0]        vli_size,
  output logic [3:0]        code_size,
  output logic              valid,
  output logic [3:0]        run_q,
  output logic [3:0]        vli_size_q,
  output logic [3:0]        code_size_q,
  output logic              valid_q
);
  logic [7:0] sym;
  // Entry layout {size[3:0], code[15:0], symbol[7:0]}; scan from the top so the lowest matching index is the one left standing
  always_comb begin
    valid = 1'b0;
    sym = '0;
    code_size = '0;
    for (int i = H - 1; i >= 0; i--)
      if (huff_table[i][27:24] != 4'd0 && huff_table[i][23:8] == code) begin
        valid = 1'b1;
        sym = huff_table[i][7:0];
        code_size = huff_table[i][27:24];
      end
  end
  assign run = sym[7:4];
  assign vli_size = sym[3:0];
  // Registered copy of the combinational decode, cleared asynchronously
  always_ff @(posedge clk or posedge reset)
    if (reset) {valid_q, run_q, vli_size_q, code_size_q} <= '0;
    else {valid_q, run_q, vli_size_q, code_size_q} <= {valid, run, vli_size, code_size};
endmodule

// File: tb/tb_jpeg_huffman_decoder.sv
// tb_jpeg_huffman_decoder: directed vectors checked against a first-match table model every cycle
module tb_jpeg_huffman_decoder;
  typedef struct {
    logic [3:0]  sz;
    logic [15:0] cd;
    logic [7:0]  sy;
  } ent_t;

  logic              clk;
  logic              reset;
  logic [15:0][27:0] tbl;
  logic [15:0]       code;
  logic [3:0]        run, vli_size, code_size, run_q, vli_size_q, code_size_q;
  logic              valid, valid_q;

  ent_t ents[16];
  int   total = 0;
  int   bad = 0;
  bit   started = 0;
  logic [12:0] exp_q;

  jpeg_huffman_decoder #(.H(16)) dut (
    .clk(clk), .reset(reset), .huff_table(tbl), .code(code),
    .run(run), .vli_size(vli_size), .code_size(code_size), .valid(valid),
    .run_q(run_q), .vli_size_q(vli_size_q), .code_size_q(code_size_q), .valid_q(valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result packed as {valid, symbol[7:0], size[3:0]}; first entry in index order that is in use and equal wins
  function automatic logic [12:0] model(input logic [15:0] c);
    for (int i = 0; i < 16; i++)
      if (ents[i].sz != 4'd0 && ents[i].cd == c) return {1'b1, ents[i].sy, ents[i].sz};
    return 13'd0;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic load();
    for (int i = 0; i < 16; i++) tbl[i] = {ents[i].sz, ents[i].cd, ents[i].sy};
  endtask

  task automatic clear_tab();
    for (int i = 0; i < 16; i++) ents[i] = '{4'd0, 16'd0, 8'd0};
  endtask

  task automatic lit(input string tag, input logic v, input logic [3:0] r, input logic [3:0] s, input logic [3:0] cs);
    chk({tag, "_valid"}, {15'd0, valid}, {15'd0, v});
    chk({tag, "_run"}, {12'd0, run}, {12'd0, r});
    chk({tag, "_vli"}, {12'd0, vli_size}, {12'd0, s});
    chk({tag, "_csize"}, {12'd0, code_size}, {12'd0, cs});
  endtask

  task automatic apply(input logic [15:0] c);
    @(posedge clk);
    #2 code = c;
    #1;
  endtask

  // Expected registered outputs: a clock edge captures the model, reset forces zero
  always @(posedge clk or posedge reset)
    if (reset) exp_q <= 13'd0;
    else exp_q <= model(code);

  // Every cycle, away from the active edge, compare both output sets with the model
  always @(negedge clk)
    if (started) begin
      logic [12:0] e;
      logic [12:0] eq;
      e = model(code);
      eq = reset ? 13'd0 : exp_q;
      chk("cmp_valid", {15'd0, valid}, {15'd0, e[12]});
      chk("cmp_run", {12'd0, run}, {12'd0, e[11:8]});
      chk("cmp_vli", {12'd0, vli_size}, {12'd0, e[7:4]});
      chk("cmp_csize", {12'd0, code_size}, {12'd0, e[3:0]});
      chk("cmp_valid_q", {15'd0, valid_q}, {15'd0, eq[12]});
      chk("cmp_run_q", {12'd0, run_q}, {12'd0, eq[11:8]});
      chk("cmp_vli_q", {12'd0, vli_size_q}, {12'd0, eq[7:4]});
      chk("cmp_csize_q", {12'd0, code_size_q}, {12'd0, eq[3:0]});
    end

  initial begin
    logic [15:0] codes[10];
    reset = 1'b1;
    code = 16'd0;
    clear_tab();
    load();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_q", {15'd0, valid_q}, 16'd0);
    chk("rst_fields_q", {4'd0, run_q, vli_size_q, code_size_q}, 16'd0);
    #1 reset = 1'b0;
    started = 1'b1;

    ents[0] = '{4'd5, 16'h0015, 8'h69};
    ents[1] = '{4'd2, 16'h0003, 8'h01};
    ents[2] = '{4'd9, 16'h0023, 8'h34};
    load();
    apply(16'h0015); lit("t15", 1'b1, 4'd6, 4'd9, 4'd5);
    apply(16'h0003); lit("t03", 1'b1, 4'd0, 4'd1, 4'd2);
    apply(16'h0023); lit("t23", 1'b1, 4'd3, 4'd4, 4'd9);
    apply(16'h0069); lit("t69", 1'b0, 4'd0, 4'd0, 4'd0);

    ents[5] = '{4'd5, 16'h0015, 8'h12};
    ents[3] = '{4'd0, 16'h0000, 8'h55};
    apply(16'h0015); load(); #1;
    lit("dup", 1'b1, 4'd6, 4'd9, 4'd5);
    apply(16'h0000); lit("sz0", 1'b0, 4'd0, 4'd0, 4'd0);

    apply(16'h0015);
    @(posedge clk);
    #1;
    chk("reg_valid_q", {15'd0, valid_q}, 16'd1);
    chk("reg_run_q", {12'd0, run_q}, 16'd6);
    chk("reg_vli_q", {12'd0, vli_size_q}, 16'd9);
    chk("reg_csize_q", {12'd0, code_size_q}, 16'd5);
    #1 reset = 1'b1;
    #1;
    chk("arst_q", {3'd0, valid_q, run_q, vli_size_q, code_size_q}, 16'd0);
    lit("arst_comb", 1'b1, 4'd6, 4'd9, 4'd5);
    @(posedge clk);
    #1;
    chk("hold_q", {3'd0, valid_q, run_q, vli_size_q, code_size_q}, 16'd0);
    #1 reset = 1'b0;

    ents[6] = '{4'd4, 16'h000A, 8'h00};
    ents[7] = '{4'd11, 16'h07F9, 8'hF0};
    load();
    apply(16'h000A); lit("eob", 1'b1, 4'd0, 4'd0, 4'd4);
    apply(16'h07F9); lit("zrl", 1'b1, 4'd15, 4'd0, 4'd11);

    codes = '{16'h0015, 16'h0001, 16'hFFFF, 16'h0023, 16'h000A, 16'h0003, 16'h8015, 16'h07F9, 16'h0000, 16'h0015};
    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin
        ents[0].sz = 4'd0;
        load();
      end
      apply(codes[k]);
    end
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
